// File: rtl/intc_pkg.sv
// Shared types and constants for the intc_prio priority interrupt controller.
package intc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    SERVICE = 2'd2
  } state_e;

  // Field positions inside the 32-bit intc_test status word.
  localparam int TST_PEND_LSB  = 0;
  localparam int TST_MASK_LSB  = 4;
  localparam int TST_STATE_LSB = 8;
  localparam int TST_STATE_W   = 2;
  localparam int TST_ID_LSB    = 10;
  localparam int TST_CNT_LSB   = 16;
  localparam int TST_CNT_W     = 16;

  localparam int DEF_VEC_STRIDE = 16;

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-first priority encoder: index 0 wins over every other request.
module intc_prio_enc #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  output logic            valid,
  output logic [ID_W-1:0] id
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/intc_prio.sv
// Edge-capturing priority interrupt controller with ack/eret handshake tracking.
// Optional INTC_SYNC_EN adds a 2-flop synchronizer on irq_in before edge detect.
module intc_prio
  import intc_pkg::*;
#(
  parameter int NUM_IRQ    = 4,
  parameter int ID_W       = 2,
  parameter int ADDR_W     = 6,
  parameter int VEC_STRIDE = DEF_VEC_STRIDE
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               cpu_ack,
  input  logic               cpu_eret,
  output logic               cpu_int,
  output logic [ADDR_W-1:0]  cpu_vec,
  output logic [31:0]        intc_test
);

  state_e                 state_q;
  logic [NUM_IRQ-1:0]     irq_src;
  logic [NUM_IRQ-1:0]     irq_q;
  logic [NUM_IRQ-1:0]     pending_q, pending_d;
  logic [NUM_IRQ-1:0]     ack_clr;
  logic [ID_W-1:0]        id_q;
  logic [ADDR_W-1:0]      vec_q;
  logic                   int_q;
  logic [TST_CNT_W-1:0]   count_q;
  logic                   sel_valid;
  logic [ID_W-1:0]        sel_id;
  logic [31:0]            test_w;

  function automatic logic [ADDR_W-1:0] vec_of(input logic [ID_W-1:0] id);
    return ADDR_W'(32'(id) * VEC_STRIDE);
  endfunction

`ifdef INTC_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_src = sync2_q;
`else
  assign irq_src = irq_in;
`endif

  // A fresh edge outranks the ack-clear on the same bit.
  assign ack_clr   = (state_q == PEND && cpu_ack) ? (NUM_IRQ'(1) << id_q) : '0;
  assign pending_d = (pending_q & ~ack_clr) | (irq_src & ~irq_q);

  intc_prio_enc #(
    .N    (NUM_IRQ),
    .ID_W (ID_W)
  ) u_enc (
    .req   (pending_q & irq_mask),
    .valid (sel_valid),
    .id    (sel_id)
  );

  // NOTE: all state here uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      irq_q     <= '0;
      pending_q <= '0;
      id_q      <= '0;
      vec_q     <= '0;
      int_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      irq_q     <= irq_src;
      pending_q <= pending_d;
      case (state_q)
        IDLE: begin
          if (sel_valid) begin
            state_q <= PEND;
            id_q    <= sel_id;
            vec_q   <= vec_of(sel_id);
            int_q   <= 1'b1;
          end
        end
        PEND: begin
          if (cpu_ack) begin
            state_q <= SERVICE;
            int_q   <= 1'b0;
          end else if (sel_valid) begin
            id_q  <= sel_id;
            vec_q <= vec_of(sel_id);
          end else begin
            state_q <= IDLE;
            int_q   <= 1'b0;
          end
        end
        SERVICE: begin
          if (cpu_eret) begin
            state_q <= IDLE;
            count_q <= count_q + TST_CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          int_q   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    test_w = '0;
    test_w[TST_PEND_LSB +: NUM_IRQ]      = pending_q;
    test_w[TST_MASK_LSB +: NUM_IRQ]      = irq_mask;
    test_w[TST_STATE_LSB +: TST_STATE_W] = state_q;
    test_w[TST_ID_LSB +: ID_W]           = id_q;
    test_w[TST_CNT_LSB +: TST_CNT_W]     = count_q;
  end

  assign cpu_int   = int_q;
  assign cpu_vec   = vec_q;
  assign intc_test = test_w;

endmodule

// File: tb/tb_intc_prio.sv
// Directed self-checking bench for intc_prio; expected values are hand-computed.
module tb_intc_prio;

`ifdef INTC_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic       sys_clk;
  logic       sys_rst;
  logic [3:0] irq_in;
  logic [3:0] irq_mask;
  logic       cpu_ack;
  logic       cpu_eret;
  logic       cpu_int;
  logic [5:0] cpu_vec;
  logic [31:0] intc_test;

  int total = 0;
  int bad   = 0;
  int n;

  intc_prio dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .irq_in    (irq_in),
    .irq_mask  (irq_mask),
    .cpu_ack   (cpu_ack),
    .cpu_eret  (cpu_eret),
    .cpu_int   (cpu_int),
    .cpu_vec   (cpu_vec),
    .intc_test (intc_test)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic ack();
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
  endtask

  task automatic eret();
    cpu_eret = 1'b1;
    tick();
    cpu_eret = 1'b0;
  endtask

  initial begin
    sys_rst  = 1'b1;
    irq_in   = 4'h0;
    irq_mask = 4'h0;
    cpu_ack  = 1'b0;
    cpu_eret = 1'b0;
    tick();
    tick();
    check("rst_int", 32'(cpu_int), 32'd0);
    check("rst_vec", 32'(cpu_vec), 32'd0);
    check("rst_test", intc_test, 32'h0);
    sys_rst  = 1'b0;
    irq_mask = 4'hF;
    tick();

    // single edge on irq 2
    irq_in = 4'b0100;
    n = 0;
    do begin
      tick();
      n++;
    end while (!cpu_int && n < 10);
    check("t1_latency", 32'(n), 32'(LAT));
    check("t1_vec", 32'(cpu_vec), 32'd32);
    check("t1_state_pend", 32'(intc_test[9:8]), 32'd1);
    check("t1_id", 32'(intc_test[11:10]), 32'd2);
    ack();
    check("t1_int_after_ack", 32'(cpu_int), 32'd0);
    check("t1_state_srv", 32'(intc_test[9:8]), 32'd2);
    check("t1_pend_cleared", 32'(intc_test[3:0]), 32'h0);
    tick();
    check("t1_level_no_repend", 32'(intc_test[3:0]), 32'h0);
    eret();
    check("t1_state_idle", 32'(intc_test[9:8]), 32'd0);
    check("t1_count", 32'(intc_test[31:16]), 32'd1);
    check("t1_int_idle", 32'(cpu_int), 32'd0);
    irq_in = 4'h0;
    tick();

`ifndef INTC_SYNC_EN
    // irq 3 then irq 1 one cycle later: vector re-arbitrates 48 -> 16
    irq_in = 4'b1000;
    tick();
    check("t2_pend3", 32'(intc_test[3:0]), 32'h8);
    irq_in = 4'b1010;
    tick();
    check("t2_int", 32'(cpu_int), 32'd1);
    check("t2_vec48", 32'(cpu_vec), 32'd48);
    tick();
    check("t2_vec16", 32'(cpu_vec), 32'd16);
    ack();
    check("t2_srv_state", 32'(intc_test[9:8]), 32'd2);
    check("t2_pend_left", 32'(intc_test[3:0]), 32'h8);
    check("t2_vec_frozen", 32'(cpu_vec), 32'd16);
    eret();
    check("t2_eret_idle", 32'(intc_test[9:8]), 32'd0);
    check("t2_eret_int", 32'(cpu_int), 32'd0);
    tick();
    check("t2_reint", 32'(cpu_int), 32'd1);
    check("t2_vec48_again", 32'(cpu_vec), 32'd48);
    ack();
    eret();
    check("t2_count", 32'(intc_test[31:16]), 32'd3);
    check("t2_pend_empty", 32'(intc_test[3:0]), 32'h0);
    irq_in = 4'h0;
    tick();

    // masked source stays pending and is not selected
    irq_mask = 4'hD;
    irq_in   = 4'b0010;
    tick();
    check("t3_pend_masked", 32'(intc_test[3:0]), 32'h2);
    tick();
    check("t3_no_int", 32'(cpu_int), 32'd0);
    check("t3_state_idle", 32'(intc_test[9:8]), 32'd0);
    check("t3_mask_mirror_d", 32'(intc_test[7:4]), 32'hD);
    irq_mask = 4'hF;
    #1;
    check("t3_mask_mirror_f", 32'(intc_test[7:4]), 32'hF);
    tick();
    check("t3_int_unmask", 32'(cpu_int), 32'd1);
    check("t3_vec16", 32'(cpu_vec), 32'd16);
    ack();
    eret();
    check("t3_count", 32'(intc_test[31:16]), 32'd4);

    // masking the selected source while in PEND drops back to IDLE
    irq_in = 4'h0;
    tick();
    irq_in = 4'b0010;
    tick();
    tick();
    check("t3b_int", 32'(cpu_int), 32'd1);
    irq_mask = 4'hD;
    tick();
    check("t3b_idle", 32'(intc_test[9:8]), 32'd0);
    check("t3b_int_low", 32'(cpu_int), 32'd0);
    check("t3b_still_pend", 32'(intc_test[3:0]), 32'h2);
    irq_mask = 4'hF;
    tick();
    check("t3b_reint", 32'(cpu_int), 32'd1);
    ack();
    eret();
    check("t3b_count", 32'(intc_test[31:16]), 32'd5);
    irq_in = 4'h0;
    tick();

    // irq 0 arriving during SERVICE of irq 2 waits for eret
    irq_in = 4'b0100;
    tick();
    tick();
    check("t4_vec32", 32'(cpu_vec), 32'd32);
    ack();
    irq_in = 4'b0101;
    tick();
    check("t4_pend0", 32'(intc_test[3:0]), 32'h1);
    check("t4_no_nest", 32'(cpu_int), 32'd0);
    tick();
    check("t4_still_srv", 32'(intc_test[9:8]), 32'd2);
    eret();
    check("t4_eret_int", 32'(cpu_int), 32'd0);
    check("t4_count", 32'(intc_test[31:16]), 32'd6);
    tick();
    check("t4_int0", 32'(cpu_int), 32'd1);
    check("t4_vec0", 32'(cpu_vec), 32'd0);
    ack();
    eret();
    irq_in = 4'h0;
    tick();

    // new edge on irq 1 coincident with its ack: set wins
    irq_in = 4'b0010;
    tick();
    irq_in = 4'b0000;
    tick();
    check("t5_int", 32'(cpu_int), 32'd1);
    irq_in  = 4'b0010;
    ack();
    check("t5_srv", 32'(intc_test[9:8]), 32'd2);
    check("t5_set_wins", 32'(intc_test[3:0]), 32'h2);
    eret();
    check("t5_count", 32'(intc_test[31:16]), 32'd8);
    tick();
    check("t5_reserve_int", 32'(cpu_int), 32'd1);
    check("t5_reserve_vec", 32'(cpu_vec), 32'd16);
    ack();
    check("t5_pend_clear", 32'(intc_test[3:0]), 32'h0);
    eret();
    check("t5_count2", 32'(intc_test[31:16]), 32'd9);
    irq_in = 4'h0;
    tick();
`endif

    // reset while in PEND with two bits pending
    irq_in = 4'b1100;
    repeat (LAT - 2) tick();
    tick();
    check("t6_pend2", 32'(intc_test[3:0]), 32'hC);
    tick();
    check("t6_in_pend", 32'(cpu_int), 32'd1);
    check("t6_vec32", 32'(cpu_vec), 32'd32);
    sys_rst  = 1'b1;
    irq_mask = 4'h0;
    irq_in   = 4'h0;
    #1;
    check("t6_rst_int", 32'(cpu_int), 32'd0);
    check("t6_rst_vec", 32'(cpu_vec), 32'd0);
    check("t6_rst_test", intc_test, 32'h0);
    tick();
    sys_rst  = 1'b0;
    irq_mask = 4'hF;
    tick();
    tick();
    check("t6_post_rst_int", 32'(cpu_int), 32'd0);
    check("t6_post_rst_pend", 32'(intc_test[3:0]), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
